// File: rtl/periph_bridge.sv
// periph_bridge: one-cycle CPU-to-MMIO bridge with a registered peripheral write bus,
// synchronized switch/button reads and a free-running loadable timer.
module periph_bridge #(
    parameter logic [31:0] BASE  = 32'hFFFF_F000,
    parameter int          SW_W  = 24,
    parameter int          BTN_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             per_wen,
    output logic [11:0]      per_addr,
    output logic [31:0]      per_wdata,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [BTN_W-1:0] btn_i
);
    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [BTN_W-1:0] btn_s1, btn_s2;
    logic [31:0]      timer, rd_val;
    logic [11:0]      off;
    logic             hit, wr_hit, ld;

    assign off    = cpu_addr[11:0];
    assign hit    = cpu_addr[31:12] == BASE[31:12];
    assign wr_hit = cpu_req && cpu_we && hit;
    assign ld     = wr_hit && off == 12'h020;
    assign rd_val = off == 12'h020 ? timer :
                    off == 12'h070 ? 32'(sw_s2) :
                    off == 12'h078 ? 32'(btn_s2) : 32'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_s1     <= '0;
            sw_s2     <= '0;
            btn_s1    <= '0;
            btn_s2    <= '0;
            timer     <= '0;
            cpu_ready <= 1'b0;
            per_wen   <= 1'b0;
            per_addr  <= '0;
            per_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            sw_s1     <= sw_i;
            sw_s2     <= sw_s1;
            btn_s1    <= btn_i;
            btn_s2    <= btn_s1;
            timer     <= ld ? cpu_wdata : timer + 32'd1;
            cpu_ready <= cpu_req;
            per_wen   <= wr_hit;
            if (wr_hit) begin
                per_addr  <= off;
                per_wdata <= cpu_wdata;
            end
            // write completions and misses return zero; idle cycles hold the last read
            if (cpu_req)
                cpu_rdata <= (!cpu_we && hit) ? rd_val : 32'd0;
        end
    end
endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge: directed scoreboard bench for periph_bridge; each step drives one
// cycle of CPU stimulus, queues the expected outputs and checks them one edge later.
module tb_periph_bridge;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata, per_wdata;
    logic        cpu_ready, per_wen;
    logic [11:0] per_addr;
    logic [23:0] sw_i = '0;
    logic [4:0]  btn_i = '0;

    typedef struct {
        logic        rdy, wen;
        logic [11:0] a;
        logic [31:0] wd, rd;
    } exp_t;
    exp_t        q[$];
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    int          total = 0, bad = 0;

    periph_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .per_wen(per_wen), .per_addr(per_addr),
        .per_wdata(per_wdata), .sw_i(sw_i), .btn_i(btn_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".ready"}, 32'(cpu_ready), 32'(e.rdy));
        chk({tag, ".wen"},   32'(per_wen),   32'(e.wen));
        chk({tag, ".addr"},  32'(per_addr),  32'(e.a));
        chk({tag, ".wdata"}, per_wdata,      e.wd);
        chk({tag, ".rdata"}, cpu_rdata,      e.rd);
    endtask

    // Called just after a rising edge: drives one cycle, then checks at the next edge.
    task automatic step(input string tag, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd_exp);
        exp_t e;
        logic hit;
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        hit = addr[31:12] == 20'hFFFFF;
        e.rdy = req;
        e.wen = req && we && hit;
        if (e.wen) begin
            m_addr = addr[11:0];
            m_wdata = wd;
        end
        if (req) m_rdata = (!we && hit) ? rd_exp : 32'd0;
        e.a = m_addr; e.wd = m_wdata; e.rd = m_rdata;
        q.push_back(e);
        @(posedge clk_i); #1;
        cpu_req = 1'b0;
        chk_all(tag, q.pop_front());
    endtask

    initial begin
        exp_t z;
        z = '{rdy: 1'b0, wen: 1'b0, a: 12'h0, wd: 32'h0, rd: 32'h0};
        #12;
        chk_all("reset", z);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        step("led_wr",   1, 1, 32'hFFFF_F060, 32'h00A5_5A3C, 0);
        step("led_idle", 0, 0, 0, 0, 0);
        step("b2b_1",    1, 1, 32'hFFFF_F060, 32'h11, 0);
        step("b2b_2",    1, 1, 32'hFFFF_F060, 32'h22, 0);
        step("b2b_idle", 0, 0, 0, 0, 0);

        step("tmr_wr",   1, 1, 32'hFFFF_F020, 32'hFFFF_FFFE, 0);
        step("tmr_gap",  0, 0, 0, 0, 0);
        step("tmr_rd",   1, 0, 32'hFFFF_F020, 0, 32'hFFFF_FFFF);
        step("tmr_wrap", 1, 0, 32'hFFFF_F020, 0, 32'h0000_0000);
        step("rd_hold",  0, 0, 0, 0, 0);

        sw_i = 24'h123456;
        step("sw_chg",   0, 0, 0, 0, 0);
        step("sw_early", 1, 0, 32'hFFFF_F070, 0, 32'h0);
        step("sw_late",  1, 0, 32'hFFFF_F070, 0, 32'h0012_3456);
        btn_i = 5'h1F;
        step("btn_chg",  0, 0, 0, 0, 0);
        step("btn_wait", 0, 0, 0, 0, 0);
        step("btn_rd",   1, 0, 32'hFFFF_F078, 0, 32'h0000_001F);

        step("miss_wr",  1, 1, 32'h0000_1060, 32'hDEAD_BEEF, 0);
        step("led_rd",   1, 0, 32'hFFFF_F060, 0, 32'h0);
        step("unmap_wr", 1, 1, 32'hFFFF_F300, 32'h0BAD_F00D, 0);
        step("sw_rd2",   1, 0, 32'hFFFF_F070, 0, 32'h0012_3456);
        step("unmap_rd", 1, 0, 32'hFFFF_F100, 0, 32'h0);
        step("miss_rd",  1, 0, 32'h1234_5070, 0, 32'h0);

        step("pre_rst",  1, 1, 32'hFFFF_F060, 32'hCAFE_F00D, 0);
        rst_i = 1'b1;
        #1;
        chk_all("rst_mid", z);
        q.delete();
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        step("post_rst", 1, 0, 32'hFFFF_F020, 0, 32'h0);
        step("post_tmr", 1, 0, 32'hFFFF_F020, 0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
